// File: rtl/serial_add_ctrl_if.sv
// Request/response and full-adder-cell signals of the bit-serial adder controller.
// The slave side is the controller; the master side is the requester plus the adder cell.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             fa_a;
  logic             fa_b;
  logic             fa_ci;
  logic             fa_s;
  logic             fa_co;

  modport master (
    output start, op_a, op_b, cin, fa_s, fa_co,
    input  busy, done, sum, cout, fa_a, fa_b, fa_ci
  );

  modport slave (
    input  start, op_a, op_b, cin, fa_s, fa_co,
    output busy, done, sum, cout, fa_a, fa_b, fa_ci
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one external full-adder cell LSB first over WIDTH
// cycles and collects the sum, with a start/busy/done handshake.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus_io
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] r_sh_q;
  logic [WIDTH-1:0] sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus_io.start) begin
            a_sh_q  <= bus_io.op_a;
            b_sh_q  <= bus_io.op_b;
            carry_q <= bus_io.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          r_sh_q  <= {bus_io.fa_s, r_sh_q[WIDTH-1:1]};
          carry_q <= bus_io.fa_co;
          a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            // Result is published only here, so sum/cout hold across IDLE and new starts.
            sum_q   <= {bus_io.fa_s, r_sh_q[WIDTH-1:1]};
            cout_q  <= bus_io.fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // The adder cell only sees operand bits while an operation is running.
  always_comb begin
    bus_io.fa_a  = 1'b0;
    bus_io.fa_b  = 1'b0;
    bus_io.fa_ci = 1'b0;
    if (state_q == StRun) begin
      bus_io.fa_a  = a_sh_q[0];
      bus_io.fa_b  = b_sh_q[0];
      bus_io.fa_ci = carry_q;
    end
  end

  assign bus_io.busy = busy_q;
  assign bus_io.done = done_q;
  assign bus_io.sum  = sum_q;
  assign bus_io.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomised checks of serial_add_ctrl (WIDTH=8) driving a behavioural full adder.
module tb_serial_add_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  assign bus.fa_s  = bus.fa_a ^ bus.fa_b ^ bus.fa_ci;
  assign bus.fa_co = (bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_ci) | (bus.fa_b & bus.fa_ci);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and watches 12 cycles starting right after the accepting edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] s, output logic co, output int busy_n,
                        output int done_n, output int done_at, output int fa_bad);
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    fa_bad  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = 8'h00;
    bus.op_b  = 8'h00;
    bus.cin   = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) begin
        done_n++;
        done_at = k;
      end
      if (bus.busy !== 1'b1 && (bus.fa_a | bus.fa_b | bus.fa_ci) !== 1'b0) fa_bad++;
    end
    s  = bus.sum;
    co = bus.cout;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = 8'h00;
    bus.op_b  = 8'h00;
    bus.cin   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.cout} !== 3'b000) begin
      $display("FAIL reset_flags: busy/done/cout=%b want 000", {bus.busy, bus.done, bus.cout});
      errors++;
    end
    checks++;
    if (bus.sum !== 8'h00) begin
      $display("FAIL reset_sum: got %h want 00", bus.sum);
      errors++;
    end
    checks++;
    if ({bus.fa_a, bus.fa_b, bus.fa_ci} !== 3'b000) begin
      $display("FAIL reset_fa: got %b want 000", {bus.fa_a, bus.fa_b, bus.fa_ci});
      errors++;
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] s;
    logic co;
    int bn, dn, da, fb;
    run_op(8'h5A, 8'h3C, 1'b0, s, co, bn, dn, da, fb);
    checks++;
    if ({co, s} !== 9'h096) begin
      $display("FAIL basic_sum: got %h want 096", {co, s});
      errors++;
    end
    checks++;
    if (bn !== 8) begin
      $display("FAIL basic_busy_cycles: got %0d want 8", bn);
      errors++;
    end
    checks++;
    if (dn !== 1 || da !== 8) begin
      $display("FAIL basic_done: pulses %0d at %0d want 1 at 8", dn, da);
      errors++;
    end
    checks++;
    if (fb !== 0) begin
      $display("FAIL basic_fa_idle: got %0d nonzero cycles want 0", fb);
      errors++;
    end
  endtask

  task automatic test_carry;
    logic [7:0] s;
    logic co;
    int bn, dn, da, fb;
    run_op(8'hFF, 8'h01, 1'b0, s, co, bn, dn, da, fb);
    checks++;
    if ({co, s} !== 9'h100) begin
      $display("FAIL carry_ff_01: got %h want 100", {co, s});
      errors++;
    end
    run_op(8'hFF, 8'hFF, 1'b1, s, co, bn, dn, da, fb);
    checks++;
    if ({co, s} !== 9'h1FF) begin
      $display("FAIL carry_ff_ff_1: got %h want 1ff", {co, s});
      errors++;
    end
  endtask

  task automatic test_ignore_start;
    int dn;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 8'h12;
    bus.op_b  = 8'h34;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op_a  = 8'hAA;
    bus.op_b  = 8'h55;
    bus.cin   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = 8'h00;
    bus.op_b  = 8'h00;
    bus.cin   = 1'b0;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    checks++;
    if ({bus.cout, bus.sum} !== 9'h046) begin
      $display("FAIL ignore_sum: got %h want 046", {bus.cout, bus.sum});
      errors++;
    end
    checks++;
    if (dn !== 1) begin
      $display("FAIL ignore_done_pulses: got %0d want 1", dn);
      errors++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL ignore_not_queued: busy=%b want 0", bus.busy);
      errors++;
    end
  endtask

  task automatic test_reset_abort;
    logic [7:0] s;
    logic co;
    int bn, dn, da, fb;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 8'h80;
    bus.op_b  = 8'h80;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL abort_flags: busy=%b done=%b want 0 0", bus.busy, bus.done);
      errors++;
    end
    checks++;
    if ({bus.cout, bus.sum} !== 9'h000) begin
      $display("FAIL abort_sum: got %h want 000", {bus.cout, bus.sum});
      errors++;
    end
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    checks++;
    if (dn !== 0) begin
      $display("FAIL abort_no_done: got %0d pulses want 0", dn);
      errors++;
    end
    run_op(8'h01, 8'h01, 1'b0, s, co, bn, dn, da, fb);
    checks++;
    if ({co, s} !== 9'h002) begin
      $display("FAIL abort_next_op: got %h want 002", {co, s});
      errors++;
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp;
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.op_a = 8'(i);
      bus.op_b = 8'(i);
      bus.cin  = i[0];
      exp      = 9'(2 * i + (i % 2));
      @(posedge clk);
      #1;
      bus.op_a = 8'hEE;
      bus.op_b = 8'hEE;
      bus.cin  = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (k == 0) begin
          checks++;
          if (bus.busy !== 1'b1) begin
            $display("FAIL b2b_accept[%0d]: busy=%b want 1", i, bus.busy);
            errors++;
          end
        end
        checks++;
        if (bus.done !== (k == 8)) begin
          $display("FAIL b2b_done[%0d] cycle %0d: got %b want %b", i, k, bus.done, k == 8);
          errors++;
        end
        if (k == 8) begin
          checks++;
          if ({bus.cout, bus.sum} !== exp) begin
            $display("FAIL b2b_sum[%0d]: got %h want %h", i, {bus.cout, bus.sum}, exp);
            errors++;
          end
        end
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_random;
    logic [7:0] a, b, s;
    logic c, co;
    logic [8:0] exp;
    int bn, dn, da, fb;
    for (int n = 0; n < 1000; n++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      c   = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + {8'h00, c};
      run_op(a, b, c, s, co, bn, dn, da, fb);
      checks++;
      if ({co, s} !== exp || dn !== 1 || da !== 8) begin
        $display("FAIL rand[%0d] %h+%h+%b: got %h done %0d@%0d want %h done 1@8",
                 n, a, b, c, {co, s}, dn, da, exp);
        errors++;
      end
      checks++;
      if (fb !== 0) begin
        $display("FAIL rand_fa_idle[%0d]: got %0d nonzero cycles want 0", n, fb);
        errors++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
